// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 key events and per-player joystick words into
// registered active-high direction/button/start/coin signals, with screen
// rotation remap and serialised, fixed-width coin pulses.
// Optional feature macro: ARCADE_INPUT_SOCD_EN (cancels opposing directions).
module arcade_input_ctrl #(
    parameter int          PLAYERS    = 2,
    parameter int          NBTN       = 2,
    parameter logic [15:0] COIN_PULSE = 16'd50000,
    parameter logic [15:0] COIN_GAP   = 16'd50000
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [64:0]              ps2_key,
    input  logic [16*PLAYERS-1:0]    joy_in,
    input  logic [1:0]               rotate,
    input  logic                     merge,
    output logic [4*PLAYERS-1:0]     dir,
    output logic [NBTN*PLAYERS-1:0]  btn,
    output logic [PLAYERS-1:0]       start,
    output logic [PLAYERS-1:0]       coin,
    output logic                     busy
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    // Key state per player; only players 0 and 1 have keys, the rest stay 0.
    logic [3:0][3:0]          r_kdir;
    logic [3:0][3:0]          r_kbtn;
    logic [3:0]               r_kstart;
    logic [3:0]               r_kcoin;
    logic                     r_toggle;

    logic [PLAYERS-1:0]       r_craw;
    logic [PLAYERS-1:0]       r_craw_d;
    logic [PLAYERS-1:0]       r_pend;
    state_t                   r_state;
    logic [15:0]              r_cnt;

    logic                     w_key_evt;
    logic                     w_ext;
    logic                     w_pressed;
    logic [15:0]              w_joy_or;
    logic [PLAYERS-1:0][15:0] w_pj;
    logic [9:0]               w_kb_pad;
    logic [4*PLAYERS-1:0]     w_dir;
    logic [NBTN*PLAYERS-1:0]  w_btn;
    logic [PLAYERS-1:0]       w_start;
    logic [PLAYERS-1:0]       w_craw;
    logic [PLAYERS-1:0]       w_pick;
    logic                     w_unused;

    assign w_key_evt = (ps2_key[64] != r_toggle) && (ps2_key[63:24] == 40'd0);
    assign w_ext     = (ps2_key[15:8] == 8'hE0) || (ps2_key[23:16] == 8'hE0);
    assign w_pressed = (ps2_key[15:8] != 8'hF0);
    assign busy      = (r_state != S_IDLE) || (|r_pend);
    assign w_unused  = ^{w_pj, r_kbtn, r_kdir, r_kstart, r_kcoin, w_kb_pad};

    // {up,down,left,right} remap for screen rotation.
    function automatic logic [3:0] f_rot(input logic [3:0] d, input logic [1:0] r);
        case (r)
            2'd1:    f_rot = {d[1], d[0], d[2], d[3]};
            2'd2:    f_rot = {d[2], d[3], d[0], d[1]};
            2'd3:    f_rot = {d[0], d[1], d[3], d[2]};
            default: f_rot = d;
        endcase
    endfunction

    function automatic logic [3:0] f_socd(input logic [3:0] d);
`ifdef ARCADE_INPUT_SOCD_EN
        logic [3:0] o;
        o = d;
        if (d[3] && d[2]) o[3:2] = 2'b00;
        if (d[1] && d[0]) o[1:0] = 2'b00;
        f_socd = o;
`else
        f_socd = d;
`endif
    endfunction

    // Key event decode into the per-key pressed state; toggle copy always tracks input.
    always_ff @(posedge clk_sys) begin
        r_toggle <= ps2_key[64];
        if (reset) begin
            r_kdir   <= '0;
            r_kbtn   <= '0;
            r_kstart <= '0;
            r_kcoin  <= '0;
        end else if (w_key_evt) begin
            if (w_ext) begin
                case (ps2_key[7:0])
                    8'h75:   r_kdir[0][3] <= w_pressed;
                    8'h72:   r_kdir[0][2] <= w_pressed;
                    8'h6B:   r_kdir[0][1] <= w_pressed;
                    8'h74:   r_kdir[0][0] <= w_pressed;
                    default: ;
                endcase
            end else begin
                case (ps2_key[7:0])
                    8'h14:   r_kbtn[0][0] <= w_pressed;
                    8'h11:   r_kbtn[0][1] <= w_pressed;
                    8'h29:   r_kbtn[0][2] <= w_pressed;
                    8'h12:   r_kbtn[0][3] <= w_pressed;
                    8'h16:   r_kstart[0]  <= w_pressed;
                    8'h2E:   r_kcoin[0]   <= w_pressed;
                    8'h2D:   r_kdir[1][3] <= w_pressed;
                    8'h2B:   r_kdir[1][2] <= w_pressed;
                    8'h23:   r_kdir[1][1] <= w_pressed;
                    8'h34:   r_kdir[1][0] <= w_pressed;
                    8'h1C:   r_kbtn[1][0] <= w_pressed;
                    8'h1B:   r_kbtn[1][1] <= w_pressed;
                    8'h1E:   r_kstart[1]  <= w_pressed;
                    8'h36:   r_kcoin[1]   <= w_pressed;
                    default: ;
                endcase
            end
        end
    end

    // Combine keys with joystick words, apply merge, rotation and SOCD.
    always_comb begin
        w_joy_or = '0;
        w_pj     = '0;
        w_kb_pad = '0;
        w_dir    = '0;
        w_btn    = '0;
        w_start  = '0;
        w_craw   = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            w_joy_or = w_joy_or | joy_in[16*p +: 16];
        end
        for (int p = 0; p < PLAYERS; p++) begin
            if (!merge)      w_pj[p] = joy_in[16*p +: 16];
            else if (p == 0) w_pj[p] = w_joy_or;
            else             w_pj[p] = '0;
            w_kb_pad = {6'd0, r_kbtn[p]};
            w_dir[4*p +: 4] = f_socd(f_rot(w_pj[p][3:0] | r_kdir[p], rotate));
            for (int i = 0; i < NBTN; i++) begin
                w_btn[NBTN*p + i] = w_pj[p][4+i] | w_kb_pad[i];
            end
            w_start[p] = w_pj[p][4+NBTN] | r_kstart[p];
            w_craw[p]  = w_pj[p][5+NBTN] | r_kcoin[p];
        end
    end

    // Lowest-index pending coin request.
    always_comb begin
        w_pick = '0;
        for (int p = PLAYERS - 1; p >= 0; p--) begin
            if (r_pend[p]) begin
                w_pick    = '0;
                w_pick[p] = 1'b1;
            end
        end
    end

    // Registered player outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dir   <= '0;
            btn   <= '0;
            start <= '0;
        end else begin
            dir   <= w_dir;
            btn   <= w_btn;
            start <= w_start;
        end
    end

    // Coin edge capture and pulse/gap serialiser; a new edge wins over the IDLE clear.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_craw   <= '0;
            r_craw_d <= '0;
            r_pend   <= '0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            coin     <= '0;
        end else begin
            r_craw   <= w_craw;
            r_craw_d <= r_craw;
            if (r_state == S_IDLE) r_pend <= (r_pend & ~w_pick) | (r_craw & ~r_craw_d);
            else                   r_pend <= r_pend | (r_craw & ~r_craw_d);
            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        coin    <= w_pick;
                        r_cnt   <= COIN_PULSE - 16'd1;
                        r_state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == 16'd0) begin
                        coin    <= '0;
                        r_cnt   <= COIN_GAP - 16'd1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_GAP: begin
                    coin <= '0;
                    if (r_cnt == 16'd0) r_state <= S_IDLE;
                    else                r_cnt   <= r_cnt - 16'd1;
                end
                default: begin
                    coin    <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arcade_input_ctrl.md
# arcade_input_ctrl

Parametrised player-input front end for arcade cores. It merges PS/2 keyboard events and per-player MiSTer joystick words into registered, active-high direction, button, start and coin signals. Directions are remapped for 0/90/180/270 degree screen rotation, and coin requests are serialised into fixed-width pulses. It sits between `hps_io` and the game core's active-low input registers; the core wrapper does the inversion.

## Interface
Parameters:
- `PLAYERS`, default 2: number of players, 1..4.
- `NBTN`, default 2: action buttons per player, 1..10.
- `COIN_PULSE`, default 16'd50000: cycles that a coin output stays high.
- `COIN_GAP`, default 16'd50000: idle cycles after each coin pulse before the next one.

Ports:
- `clk_sys` in, 1: single clock; every register is on its rising edge.
- `reset` in, 1: synchronous, active-high.
- `ps2_key` in, 65: `hps_io` key format. Bit 64 is the toggle, [15:8] = F0 means release, [23:16]/[15:8] = E0 means extended.
- `joy_in` in, 16*PLAYERS: joystick words, player p at [16p+15:16p].
- `rotate` in, 2: 0 none, 1 = 90, 2 = 180, 3 = 270.
- `merge` in, 1: when 1, all joystick words are ORed and the result drives player 0 only.
- `dir` out, 4*PLAYERS: per player {up, down, left, right}, with up in the MSB.
- `btn` out, NBTN*PLAYERS: action buttons.
- `start` out, PLAYERS: start buttons.
- `coin` out, PLAYERS: serialised coin pulses.
- `busy` out, 1: coin FSM is not IDLE, or a coin request is pending.

## Operation
- **Joystick word layout:** [0] right, [1] left, [2] down, [3] up, [4+i] button i, [4+NBTN] start, [5+NBTN] coin.
- **Key event detection:** a key event is a change of `ps2_key[64]` against its registered copy. Events with `ps2_key[63:24]` != 0 (PrtScr, Pause) are ignored.
- **Keyboard map, player 0:**
  - Extended arrows: E0 75 up, E0 72 down, E0 6B left, E0 74 right.
  - Buttons: 14, 11, 29, 12 map to buttons 0..3.
  - 16 = start, 2E = coin.
- **Keyboard map, player 1:**
  - 2D up, 2B down, 23 left, 34 right.
  - Buttons: 1C, 1B map to buttons 0..1.
  - 1E = start, 36 = coin.
- **Unmapped keys:** buttons beyond those listed, players 2 and 3, and keys not mapped to an existing player or button are ignored.
- **Key state:** each mapped key's state register follows "pressed", i.e. [15:8] != F0.
- **Input combination:** per player, raw = key state OR joystick bits. With `merge`=1, players above 0 get only their key state.
- **Rotation (per player, after combination):**
  - 90: up=left, down=right, left=down, right=up.
  - 180: up=down, down=up, left=right, right=left.
  - 270: up=right, down=left, left=up, right=down.
- **Coin requests:** a rising edge of raw coin[p] sets `pend[p]`. Repeated edges while `pend[p]` is set coalesce into one request.
- **Coin FSM states:**
  - IDLE: if any `pend` bit is set, take the lowest index p, clear `pend[p]`, load the counter with COIN_PULSE-1, go to PULSE.
  - PULSE: drives `coin[p]`=1. When the counter reaches 0, load COIN_GAP-1 and go to GAP.
  - GAP: drives `coin` = 0. When the counter reaches 0, go to IDLE.
- **Counter:** 16-bit down counter, no wrap-around; a load always precedes a decrement from 0.
- **Simultaneous events:** a new edge on the player currently in PULSE sets `pend` again and is served after GAP. A press and a release in the same cycle cannot occur, since one event is processed per cycle.

## Timing
- **Reset values:**
  - Every output is 0.
  - Key state, `pend` and the edge-detect history are cleared, and the FSM is in IDLE.
  - The toggle copy loads `ps2_key[64]`, so there is no spurious event after reset.
- **Reset mid-pulse:** `coin` is 0 in the cycle after `reset` is sampled.
- **Joystick latency:** a `joy_in` change reaches `dir`/`btn`/`start` 1 cycle later.
- **Key latency:** a `ps2_key` toggle reaches the outputs 2 cycles later (key state register, then output register).
- **Coin latency:**
  - Raw coin rising edge to `pend` set: 2 cycles for joystick, 3 for keyboard.
  - `pend` set to `coin` high: 1 cycle.
- **Coin width:** the pulse is exactly COIN_PULSE cycles, and the gap between consecutive pulses is exactly COIN_GAP+1 cycles, the +1 being the IDLE selection cycle.
- **Rotation changes:** `rotate` and `merge` changes apply 1 cycle later. They do not disturb the FSM.

## Configuration
- **`ARCADE_INPUT_SOCD_EN` defined:** per player, after rotation, up+down both set gives neither, and left+right both set gives neither. Latency is unchanged.
- **Not defined:** opposing directions pass through unmodified.

## Test plan
- **Reset, then joystick:** reset, then `joy_in[3:0]`=4'b1001 with `rotate`=0. Expect `dir[3:0]`=4'b1001 exactly one cycle later, and all outputs 0 during reset.
- **Keyboard press/release:** key event E0 75 makes player 0 up=1 two cycles after the toggle. Event F0/E0 75 makes it 0 two cycles after its toggle. Event 0x5A changes nothing.
- **Rotation:** joystick left only on player 0. Expect `rotate`=1 gives up, 2 gives right, 3 gives down.
- **Coin serialisation:** COIN_PULSE=4, COIN_GAP=3, coin edges on players 1 and 0 in the same cycle. Expect `coin[0]` high 4 cycles, low 4 cycles, then `coin[1]` high 4 cycles, with `busy` high throughout.
- **Reset mid-pulse:** assert `reset` during PULSE. Expect `coin`=0 and `busy`=0 on the next cycle, with no pending pulse afterwards.
- **SOCD:** with `ARCADE_INPUT_SOCD_EN`, up+down+left gives `dir`=4'b0010. Without it, the same input gives 4'b1110.
